// File: rtl/instr_fetch.sv
// Instruction fetch / PC unit: owns the PC and runs an IDLE/REQ/DONE handshake with imem.
// Optional macro FETCH_TIMEOUT_EN adds a REQ watchdog driving a sticky fetch_err.
module instr_fetch #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned INSTR_W = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_fetch_pulse,
    input  logic               en_pc_pulse,
    input  logic [1:0]         pc_ctrl,
    input  logic [ADDR_W-1:0]  jmp_addr,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               mem_ack,
    output logic [ADDR_W-1:0]  pc,
    output logic               en1,
    output logic [3:0]         opcode,
    output logic [1:0]         rd,
    output logic [1:0]         rs,
    output logic               fetch_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               accept;
    logic               req_expire;

    assign accept = (state_q == IDLE) && en_fetch_pulse;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    // Expire at the end of the last allowed REQ cycle; an ack in that cycle still wins.
    assign req_expire = (state_q == REQ) && !mem_ack && (cnt_q == CntW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = '0;
        if (state_q == REQ) begin
            cnt_d = cnt_q + {{(CntW-1){1'b0}}, 1'b1};
        end
        err_d = err_q;
        if (accept) begin
            err_d = 1'b0;
        end else if (req_expire) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign fetch_err = err_q;
`else
    assign req_expire = 1'b0;
    assign fetch_err  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ir_d    = ir_q;
        case (state_q)
            IDLE: begin
                if (en_fetch_pulse) begin
                    state_d = REQ;
                    addr_d  = pc_q;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_d = DONE;
                    ir_d    = mem_rdata;
                end else if (req_expire) begin
                    state_d = IDLE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (en_pc_pulse) begin
            case (pc_ctrl)
                2'b01:   pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                2'b10:   pc_d = jmp_addr;
                2'b11:   pc_d = '0;
                default: pc_d = pc_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            addr_q  <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
        end
    end

    assign mem_req  = (state_q == REQ);
    assign mem_addr = addr_q;
    assign pc       = pc_q;
    assign en1      = (state_q == DONE);
    assign opcode   = ir_q[7:4];
    assign rd       = ir_q[3:2];
    assign rs       = ir_q[1:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table, reset/timeout sequences,
// then random stimulus against a transaction-level reference model.
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_fetch_pulse = 1'b0;
    logic       en_pc_pulse = 1'b0;
    logic [1:0] pc_ctrl = 2'b00;
    logic [7:0] jmp_addr = 8'h00;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata = 8'h00;
    logic       mem_ack = 1'b0;
    logic [7:0] pc;
    logic       en1;
    logic [3:0] opcode;
    logic [1:0] rd;
    logic [1:0] rs;
    logic       fetch_err;

    int checks = 0;
    int errors = 0;

    instr_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en_fetch_pulse (en_fetch_pulse),
        .en_pc_pulse    (en_pc_pulse),
        .pc_ctrl        (pc_ctrl),
        .jmp_addr       (jmp_addr),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .pc             (pc),
        .en1            (en1),
        .opcode         (opcode),
        .rd             (rd),
        .rs             (rs),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       f;
        logic       p;
        logic [1:0] c;
        logic [7:0] j;
        logic       a;
        logic [7:0] d;
        logic [7:0] e_pc;
        logic       e_req;
        logic [7:0] e_addr;
        logic       e_en1;
        logic [7:0] e_ir;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs[NVEC];

    // Reference model: one outstanding transaction, completion flag, PC value.
    logic [7:0] m_pc, m_addr, m_ir;
    bit         m_busy, m_done, m_err;
    int         m_wait;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 8'h00; m_addr = 8'h00; m_ir = 8'h00;
        m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_wait = 0;
    endtask

    task automatic model_edge(input logic f, input logic p, input logic [1:0] c,
                              input logic [7:0] j, input logic a, input logic [7:0] d);
        bit was_done;
        was_done = m_done;
        m_done   = 1'b0;
        if (m_busy) begin
            m_wait++;
            if (a) begin
                m_ir   = d;
                m_busy = 1'b0;
                m_done = 1'b1;
            end
`ifdef FETCH_TIMEOUT_EN
            else if (m_wait == 15) begin
                m_busy = 1'b0;
                m_err  = 1'b1;
            end
`endif
        end else if (!was_done && f) begin
            m_busy = 1'b1;
            m_addr = m_pc;
            m_wait = 0;
            m_err  = 1'b0;
        end
        if (p) begin
            case (c)
                2'b01:   m_pc = 8'((int'(m_pc) + 1) % 256);
                2'b10:   m_pc = j;
                2'b11:   m_pc = 8'h00;
                default: ;
            endcase
        end
    endtask

    task automatic step(input logic f, input logic p, input logic [1:0] c,
                        input logic [7:0] j, input logic a, input logic [7:0] d);
        en_fetch_pulse = f; en_pc_pulse = p; pc_ctrl = c; jmp_addr = j;
        mem_ack = a; mem_rdata = d;
        @(posedge clk);
        #1;
        model_edge(f, p, c, j, a, d);
        en_fetch_pulse = 1'b0; en_pc_pulse = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic check_model();
        chk("pc", pc, m_pc);
        chk("mem_req", 8'(mem_req), 8'(m_busy));
        chk("mem_addr", mem_addr, m_addr);
        chk("en1", 8'(en1), 8'(m_done));
        chk("opcode", 8'(opcode), 8'(m_ir[7:4]));
        chk("rd", 8'(rd), 8'(m_ir[3:2]));
        chk("rs", 8'(rs), 8'(m_ir[1:0]));
        chk("fetch_err", 8'(fetch_err), 8'(m_err));
    endtask

    function automatic vec_t mk(logic f, logic p, logic [1:0] c, logic [7:0] j, logic a,
                                logic [7:0] d, logic [7:0] epc, logic ereq,
                                logic [7:0] eaddr, logic een1, logic [7:0] eir);
        vec_t v;
        v.f = f; v.p = p; v.c = c; v.j = j; v.a = a; v.d = d;
        v.e_pc = epc; v.e_req = ereq; v.e_addr = eaddr; v.e_en1 = een1; v.e_ir = eir;
        return v;
    endfunction

    initial begin
        // Fetch with increment, PC wrap/load/clear, delayed ack with ignored pulses,
        // pulse in DONE ignored, ack outside REQ ignored.
        vecs[0]  = mk(1'b1, 1'b1, 2'b01, 8'h00, 1'b0, 8'h00, 8'h01, 1'b1, 8'h00, 1'b0, 8'h00);
        vecs[1]  = mk(1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 8'h5B, 8'h01, 1'b0, 8'h00, 1'b1, 8'h5B);
        vecs[2]  = mk(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 8'h01, 1'b0, 8'h00, 1'b0, 8'h5B);
        vecs[3]  = mk(1'b0, 1'b1, 2'b10, 8'hFF, 1'b0, 8'h00, 8'hFF, 1'b0, 8'h00, 1'b0, 8'h5B);
        vecs[4]  = mk(1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h5B);
        vecs[5]  = mk(1'b0, 1'b1, 2'b10, 8'h3C, 1'b0, 8'h00, 8'h3C, 1'b0, 8'h00, 1'b0, 8'h5B);
        vecs[6]  = mk(1'b0, 1'b1, 2'b11, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h5B);
        vecs[7]  = mk(1'b0, 1'b1, 2'b00, 8'hAA, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h5B);
        vecs[8]  = mk(1'b0, 1'b0, 2'b10, 8'h55, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h5B);
        vecs[9]  = mk(1'b1, 1'b1, 2'b10, 8'h20, 1'b0, 8'h00, 8'h20, 1'b1, 8'h00, 1'b0, 8'h5B);
        vecs[10] = mk(1'b1, 1'b1, 2'b01, 8'h00, 1'b0, 8'h00, 8'h21, 1'b1, 8'h00, 1'b0, 8'h5B);
        vecs[11] = mk(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 8'h21, 1'b1, 8'h00, 1'b0, 8'h5B);
        vecs[12] = mk(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 8'h21, 1'b1, 8'h00, 1'b0, 8'h5B);
        vecs[13] = mk(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 8'h21, 1'b1, 8'h00, 1'b0, 8'h5B);
        vecs[14] = mk(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 8'h21, 1'b1, 8'h00, 1'b0, 8'h5B);
        vecs[15] = mk(1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 8'hA7, 8'h21, 1'b0, 8'h00, 1'b1, 8'hA7);
        vecs[16] = mk(1'b1, 1'b0, 2'b00, 8'h00, 1'b1, 8'h11, 8'h21, 1'b0, 8'h00, 1'b0, 8'hA7);
        vecs[17] = mk(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 8'h21, 1'b1, 8'h21, 1'b0, 8'hA7);
        vecs[18] = mk(1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 8'hC4, 8'h21, 1'b0, 8'h21, 1'b1, 8'hC4);
        vecs[19] = mk(1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 8'h99, 8'h21, 1'b0, 8'h21, 1'b0, 8'hC4);

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc, 8'h00);
        chk("rst_req", 8'(mem_req), 8'h00);
        chk("rst_addr", mem_addr, 8'h00);
        chk("rst_en1", 8'(en1), 8'h00);
        chk("rst_ir", {opcode, rd, rs}, 8'h00);
        chk("rst_err", 8'(fetch_err), 8'h00);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].f, vecs[i].p, vecs[i].c, vecs[i].j, vecs[i].a, vecs[i].d);
            chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
            chk($sformatf("v%0d_req", i), 8'(mem_req), 8'(vecs[i].e_req));
            chk($sformatf("v%0d_addr", i), mem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_en1", i), 8'(en1), 8'(vecs[i].e_en1));
            chk($sformatf("v%0d_ir", i), {opcode, rd, rs}, vecs[i].e_ir);
        end

        // Reset in the middle of REQ, then a late ack after release.
        step(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00);
        chk("midrst_req_before", 8'(mem_req), 8'h01);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_req_async", 8'(mem_req), 8'h00);
        chk("midrst_ir_async", {opcode, rd, rs}, 8'h00);
        model_reset();
        rst_n = 1'b1;
        step(1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 8'hFF);
        chk("midrst_en1", 8'(en1), 8'h00);
        chk("midrst_ir", {opcode, rd, rs}, 8'h00);
        chk("midrst_req", 8'(mem_req), 8'h00);
        step(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00);
        chk("midrst_en1_late", 8'(en1), 8'h00);

`ifdef FETCH_TIMEOUT_EN
        // No ack: mem_req held for exactly 15 cycles, then error without en1.
        step(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00);
        for (int i = 1; i <= 15; i++) begin
            step(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00);
            chk($sformatf("to_req_%0d", i), 8'(mem_req), (i < 15) ? 8'h01 : 8'h00);
        end
        chk("to_err", 8'(fetch_err), 8'h01);
        chk("to_en1", 8'(en1), 8'h00);
        chk("to_ir", {opcode, rd, rs}, 8'h00);
        step(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00);
        chk("to_err_sticky", 8'(fetch_err), 8'h01);
        chk("to_en1_after", 8'(en1), 8'h00);
        // Next fetch clears the flag; ack in the final allowed cycle completes normally.
        step(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00);
        chk("to_err_clr", 8'(fetch_err), 8'h00);
        for (int i = 1; i < 15; i++) begin
            step(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00);
        end
        chk("to_req_last", 8'(mem_req), 8'h01);
        step(1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 8'h3E);
        chk("to_last_en1", 8'(en1), 8'h01);
        chk("to_last_err", 8'(fetch_err), 8'h00);
        chk("to_last_ir", {opcode, rd, rs}, 8'h3E);
`endif

        check_model();
        for (int n = 0; n < 3000; n++) begin
            step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
                 2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom_range(0, 3) == 0),
                 8'($urandom));
            check_model();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch and program-counter unit feeding the control state machine. It owns the PC. It applies one-cycle `en_pc_pulse` PC commands and runs a request/acknowledge read against instruction memory on each `en_fetch_pulse`. It loads the instruction register, then returns a one-cycle `en1` done pulse together with decoded `opcode`/`rd`/`rs` fields, which the controller consumes in IF/ID.

## Interface
- `ADDR_W`, 8: PC and instruction-memory address width.
- `INSTR_W`, 8: instruction width, fixed at 8 in this design. Format: `[7:4]` opcode, `[3:2]` rd, `[1:0]` rs.
- `TIMEOUT`, 15: maximum REQ cycles without `mem_ack`. Only used with `FETCH_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en_fetch_pulse`  in  1  start one fetch at the current PC.
- `en_pc_pulse`  in  1  apply `pc_ctrl` this cycle.
- `pc_ctrl`  in  2  PC command: 00 hold, 01 increment, 10 load `jmp_addr`, 11 clear to 0.
- `jmp_addr`  in  ADDR_W  jump target.
- `mem_req`  out  1  read request, held until acknowledged.
- `mem_addr`  out  ADDR_W  read address, stable while `mem_req`=1.
- `mem_rdata`  in  INSTR_W  read data, valid in the `mem_ack` cycle.
- `mem_ack`  in  1  one-cycle read completion.
- `pc`  out  ADDR_W  current PC.
- `en1`  out  1  fetch done; one-cycle pulse.
- `opcode`  out  4  IR[7:4].
- `rd`  out  2  IR[3:2].
- `rs`  out  2  IR[1:0].
- `fetch_err`  out  1  timeout flag; constant 0 when timeout is not compiled in.

## Operation
- All outputs are registered or decoded directly from registers. No combinational path runs from inputs to outputs.
- State machine states are IDLE, REQ and DONE.
  - IDLE → REQ when `en_fetch_pulse`=1. At that edge: `mem_addr` ← `pc` (pre-update value), `mem_req` ← 1.
  - REQ → DONE at the edge where `mem_ack`=1. At that edge: IR ← `mem_rdata`, `mem_req` ← 0.
  - DONE → IDLE unconditionally. `en1`=1 only while in DONE.
- `en_fetch_pulse` in REQ or DONE is ignored: no queueing, and `mem_addr` is unchanged.
- `mem_ack` outside REQ is ignored.
- PC update on `en_pc_pulse`, in any state:
  - 01: `pc` ← `pc`+1, wrapping modulo 2^ADDR_W (all-ones → 0).
  - 10: `pc` ← `jmp_addr`.
  - 11: `pc` ← 0.
  - 00: no change.
- `en_fetch_pulse` and `en_pc_pulse` in the same cycle (the normal controller IF entry): the fetch uses the old PC and the PC update also takes effect. Result: `mem_addr`=old PC, `pc`=new PC.
- `opcode`/`rd`/`rs` hold their value until the next IR load. They are not cleared between fetches.
- Reset mid-fetch: the state machine returns to IDLE immediately, `mem_req` drops, and any late `mem_ack` is ignored.

## Timing
- Reset values: `pc`=0, `mem_req`=0, `mem_addr`=0, IR=0 (so `opcode`=0, `rd`=0, `rs`=0), `en1`=0, `fetch_err`=0, state IDLE.
- Fetch latency:
  - `en_fetch_pulse` in cycle T → `mem_req`=1 from T+1.
  - First `mem_ack` in cycle T+k (k≥1) → IR and fields are valid from T+k+1, with `en1`=1 for exactly cycle T+k+1.
  - Minimum latency, pulse to `en1`: 2 cycles.
- `pc` updates at the edge ending the `en_pc_pulse` cycle, so the new value is visible from the next cycle.
- Back-to-back fetches: a pulse in the DONE cycle is ignored. The earliest accepted pulse is in the cycle after DONE.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - A counter runs in REQ, cleared on REQ entry.
  - If TIMEOUT cycles elapse in REQ without `mem_ack`, `mem_req` drops, the state returns to IDLE, `en1` is not asserted, IR is unchanged, and `fetch_err` ← 1.
  - `fetch_err` is sticky. It is cleared by reset or by the next accepted `en_fetch_pulse`.
  - `mem_ack` arriving in the final allowed cycle wins: normal completion, no error.
- `FETCH_TIMEOUT_EN` undefined: REQ waits indefinitely, `fetch_err` is tied to 0, and there is no counter logic.

## Test plan
- Reset, then `en_fetch_pulse` together with `en_pc_pulse`/`pc_ctrl`=01, PC=0; memory returns 8'h5B with `mem_ack` 1 cycle later → `mem_addr`=0, `pc`=1, `en1` high 2 cycles after the pulse, `opcode`=5, `rd`=2, `rs`=3.
- `mem_ack` delayed 6 cycles → `mem_req` and `mem_addr` stay stable for 6 cycles, and `en1` is a single pulse.
- PC=8'hFF, increment → `pc`=0. Then `pc_ctrl`=10 with `jmp_addr`=8'h3C → `pc`=8'h3C. Then `pc_ctrl`=11 → `pc`=0.
- Second `en_fetch_pulse` issued during REQ → ignored: one `mem_req` transaction, one `en1`.
- `rst_n` asserted during REQ, then `mem_ack` arrives after release → state IDLE, `en1` stays 0, IR stays 0.
- With `FETCH_TIMEOUT_EN`, no ack → `mem_req` drops after 15 cycles, `fetch_err`=1, no `en1`; the next fetch clears `fetch_err`. Ack exactly in cycle 15 → normal `en1`, `fetch_err`=0.
